imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Boot-time writer for the CORE instruction memory. It is the producing end of the instruction-fetch path: the CORE reads words, this block writes them.
- Accepts a byte stream over a valid/ready handshake and assembles bytes little-endian into IW-bit instruction words. Each word is written to sequential instruction-memory addresses from 0.
- After the last word is written, raises `start` to release the CORE.

Parameters:
- IMW, 4: instruction-memory address width; depth = 2^IMW words.
- IW, 32: instruction width in bits; must be a multiple of 8. BPW = IW/8 bytes per word (derived, localparam).

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: synchronous, active-high reset.
- in_valid, input, 1: in_data holds a valid byte.
- in_data, input, 8: stream byte.
- in_ready, output, 1: loader can accept a byte this cycle.
- im_we, output, 1: instruction-memory write strobe, one cycle per word.
- im_addr, output, IMW: write address.
- im_wdata, output, IW: write data.
- start, output, 1: CORE run enable; level, held high once asserted.
- busy, output, 1: high while in LOAD.
- err, output, 1: sticky header error flag.
- words_loaded, output, IMW+1: number of words written so far.

Behaviour:
- Byte transfer: occurs on a rising edge with in_valid && in_ready. in_ready is combinational from state only: 1 in HDR and LOAD, 0 in DONE and ERR. Bytes offered in DONE or ERR are ignored.
- Reset: while rst=1 at an edge, all of the following are cleared:
  - state <= HDR
  - in_ready=1 (follows from state HDR)
  - im_we=0, im_addr=0, im_wdata=0
  - start=0, busy=0, err=0, words_loaded=0
  - internal byte counter and word count cleared
- Reset mid-load or after DONE has the same effect: start drops to 0 the cycle after reset is sampled, and the load restarts from HDR.
- States:
  - HDR: the first accepted byte is the word count N (unsigned 8-bit).
    - 1 <= N <= 2^IMW: latch N, go to LOAD.
    - N=0 or N>2^IMW: go to ERR.
  - LOAD: shift in bytes; byte k of a word (k=0..BPW-1) fills bits [8k+7:8k].
    - On acceptance of byte BPW-1, the assembled word is registered. In the next cycle: im_we=1, im_addr=current word index, im_wdata=word, words_loaded increments.
    - Byte acceptance continues during that write cycle; there is no stall.
    - When the accepted byte completes word N, go to DONE on the same edge. in_ready is therefore 0 from the next cycle.
  - DONE: start=1 from the cycle after the final im_we pulse (final write at cycle t+1, start at t+2). Remain in DONE until rst.
  - ERR: err=1, start stays 0, no writes. Remain in ERR until rst.
- Output timing:
  - busy=1 exactly while in LOAD.
  - im_we is never high outside the cycle following a completed word.
- Address and count limits:
  - im_addr runs 0..N-1 and never wraps, because N <= 2^IMW is guaranteed by the header check.
  - words_loaded saturates at N and reaches 2^IMW for a full load, hence IMW+1 bits.
- Input stalls: gaps in in_valid inside a word hold the partial word and byte counter unchanged, with no timeout.

Test Plan:
- Reset values: hold rst for 3 cycles -> in_ready=1; im_we=0, start=0, busy=0, err=0, words_loaded=0.
- Two-word load: bytes 02, 13,00,00,00, 93,00,10,00 back-to-back -> im_we pulses with (addr 0, 0x00000013) then (addr 1, 0x00100093). Then words_loaded=2, start=1 exactly 2 cycles after the last byte is accepted, in_ready=0.
- Full depth with gaps: header 0x10, then 64 bytes with in_valid low every other cycle -> 16 writes at addr 0..15, each data matching its byte group, no wrap, words_loaded=16, start=1.
- Header errors:
  - header 0x00 -> err=1, in_ready=0, no im_we, start stays 0.
  - Repeat after reset with header 0x11 -> same response.
- Reset mid-load: header 03, 5 payload bytes, rst for 1 cycle -> outputs return to reset values, no further im_we. A new load 01, AA,BB,CC,DD then writes 0xDDCCBBAA to addr 0.
- Post-DONE stimulus: after a completed load, drive in_valid=1 with 0xFF for 10 cycles -> no im_we, state stays DONE, start stays 1. rst then drives start to 0 on the next cycle.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: boot-time writer for the CORE instruction memory.
// Takes a byte stream (first byte = word count N), packs bytes little-endian
// into IW-bit words, writes them to addresses 0..N-1 and then releases the
// CORE by raising start. A bad header parks the block in ERR until reset.
module imem_loader #(
    parameter int IMW = 4,
    parameter int IW  = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    input  logic [7:0]     in_data,
    output logic           in_ready,
    output logic           im_we,
    output logic [IMW-1:0] im_addr,
    output logic [IW-1:0]  im_wdata,
    output logic           start,
    output logic           busy,
    output logic           err,
    output logic [IMW:0]   words_loaded
);

    localparam int BPW   = IW / 8;
    localparam int BCW   = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int DEPTH = 1 << IMW;

    localparam logic [1:0] ST_HDR  = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic [1:0] ST_ERR  = 2'd3;

    localparam logic [BCW-1:0] LAST_BYTE = BCW'(BPW - 1);
    localparam logic [BCW-1:0] BC_ZERO   = BCW'(0);
    localparam logic [BCW-1:0] BC_ONE    = BCW'(1);
    localparam logic [IMW:0]   WL_ONE    = (IMW+1)'(1);

    logic [1:0]     state_r;
    logic [1:0]     state_nxt_s;
    logic [BCW-1:0] byte_cnt_r;
    logic [IW-1:0]  word_buf_r;
    logic [IW-1:0]  word_next_s;
    logic [IMW:0]   n_r;
    logic           accept_s;
    logic           hdr_ok_s;
    logic           word_done_s;
    logic           last_word_s;
    logic           in_ready_s;

    logic           im_we_r;
    logic [IMW-1:0] im_addr_r;
    logic [IW-1:0]  im_wdata_r;
    logic           start_r;
    logic           busy_r;
    logic           err_r;
    logic [IMW:0]   words_loaded_r;

    // Handshake and per-byte decode; in_ready depends on state only.
    always_comb begin
        in_ready_s  = (state_r == ST_HDR) || (state_r == ST_LOAD);
        accept_s    = in_valid && in_ready_s;
        hdr_ok_s    = (in_data != 8'd0) && ({24'd0, in_data} <= 32'(DEPTH));
        word_done_s = (byte_cnt_r == LAST_BYTE);
        last_word_s = ((words_loaded_r + WL_ONE) == n_r);
    end

    // Insert the incoming byte into its little-endian lane of the partial word.
    always_comb begin
        word_next_s = word_buf_r;
        word_next_s[8*byte_cnt_r +: 8] = in_data;
    end

    // Next-state logic: header check, word counting, terminal DONE/ERR.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_HDR: begin
                if (accept_s) begin
                    state_nxt_s = hdr_ok_s ? ST_LOAD : ST_ERR;
                end else begin
                    state_nxt_s = ST_HDR;
                end
            end
            ST_LOAD: begin
                if (accept_s && word_done_s && last_word_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            ST_DONE: state_nxt_s = ST_DONE;
            ST_ERR:  state_nxt_s = ST_ERR;
            default: state_nxt_s = ST_ERR;
        endcase
    end

    // State, byte assembly and registered memory-write / status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= ST_HDR;
            byte_cnt_r     <= BC_ZERO;
            word_buf_r     <= {IW{1'b0}};
            n_r            <= {(IMW+1){1'b0}};
            im_we_r        <= 1'b0;
            im_addr_r      <= {IMW{1'b0}};
            im_wdata_r     <= {IW{1'b0}};
            start_r        <= 1'b0;
            busy_r         <= 1'b0;
            err_r          <= 1'b0;
            words_loaded_r <= {(IMW+1){1'b0}};
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s == ST_LOAD);
            err_r   <= (state_nxt_s == ST_ERR);
            // start lags DONE by one cycle so it follows the final write pulse.
            start_r <= (state_r == ST_DONE);
            im_we_r <= 1'b0;

            if (accept_s && (state_r == ST_HDR) && hdr_ok_s) begin
                n_r <= (IMW+1)'(in_data);
            end

            if (accept_s && (state_r == ST_LOAD)) begin
                if (word_done_s) begin
                    byte_cnt_r     <= BC_ZERO;
                    word_buf_r     <= {IW{1'b0}};
                    im_we_r        <= 1'b1;
                    im_addr_r      <= words_loaded_r[IMW-1:0];
                    im_wdata_r     <= word_next_s;
                    words_loaded_r <= words_loaded_r + WL_ONE;
                end else begin
                    byte_cnt_r <= byte_cnt_r + BC_ONE;
                    word_buf_r <= word_next_s;
                end
            end
        end
    end

    assign in_ready     = in_ready_s;
    assign im_we        = im_we_r;
    assign im_addr      = im_addr_r;
    assign im_wdata     = im_wdata_r;
    assign start        = start_r;
    assign busy         = busy_r;
    assign err          = err_r;
    assign words_loaded = words_loaded_r;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader (IMW=4, IW=32).
// Expected writes are queued when payload is driven and popped by a monitor
// whenever im_we is seen; scenario tasks check status outputs inline.
module tb_imem_loader;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        im_we;
    logic [3:0]  im_addr;
    logic [31:0] im_wdata;
    logic        start;
    logic        busy;
    logic        err;
    logic [4:0]  words_loaded;

    int tests  = 0;
    int fails  = 0;

    logic [35:0] exp_q[$];
    logic [31:0] pay_q[$];

    imem_loader #(.IMW(4), .IW(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .im_we        (im_we),
        .im_addr      (im_addr),
        .im_wdata     (im_wdata),
        .start        (start),
        .busy         (busy),
        .err          (err),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write monitor: every im_we pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (im_we === 1'b1) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write: got addr=%0d data=%h, required no write", im_addr, im_wdata);
            end else begin
                logic [35:0] e;
                e = exp_q.pop_front();
                if ({im_addr, im_wdata} !== e) begin
                    fails++;
                    $display("FAIL write: got addr=%0d data=%h, required addr=%0d data=%h",
                             im_addr, im_wdata, e[35:32], e[31:0]);
                end
            end
        end
    end

    task automatic do_reset(input int cycles);
        in_valid = 1'b0;
        rst = 1'b1;
        repeat (cycles) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
        if (gap > 0) begin
            in_valid = 1'b0;
            repeat (gap) @(posedge clk);
            #1;
        end
    endtask

    // Send header n followed by every word in pay_q, queueing expected writes.
    task automatic load(input logic [7:0] n, input int gap);
        logic [31:0] w;
        send_byte(n, gap);
        for (int i = 0; i < pay_q.size(); i++) begin
            w = pay_q[i];
            exp_q.push_back({i[3:0], w});
            for (int k = 0; k < 4; k++) begin
                send_byte(w[8*k +: 8], gap);
            end
        end
    endtask

    task automatic check_idle(input string name);
        tests++;
        if ({in_ready, im_we, start, busy, err, words_loaded, im_addr, im_wdata} !==
            {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 4'd0, 32'd0}) begin
            fails++;
            $display("FAIL %s: got rdy=%b we=%b start=%b busy=%b err=%b wl=%0d addr=%0d data=%h, required 1 0 0 0 0 0 0 0",
                     name, in_ready, im_we, start, busy, err, words_loaded, im_addr, im_wdata);
        end
    endtask

    task automatic check_queue_empty(input string name);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL %s: %0d expected writes never seen, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        do_reset(3);
        check_idle("reset_values");
    endtask

    task automatic test_two_word();
        do_reset(1);
        pay_q = '{32'h0000_0013, 32'h0010_0093};
        load(8'h02, 0);
        tests++;
        if ({im_we, start, in_ready, busy} !== 4'b1000) begin
            fails++;
            $display("FAIL two_word_last_edge: got we=%b start=%b rdy=%b busy=%b, required 1 0 0 0",
                     im_we, start, in_ready, busy);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        tests++;
        if ({start, in_ready, words_loaded, im_we} !== {1'b1, 1'b0, 5'd2, 1'b0}) begin
            fails++;
            $display("FAIL two_word_done: got start=%b rdy=%b wl=%0d we=%b, required 1 0 2 0",
                     start, in_ready, words_loaded, im_we);
        end
        check_queue_empty("two_word_writes");
    endtask

    task automatic test_full_gaps();
        do_reset(1);
        pay_q.delete();
        for (int i = 0; i < 16; i++) pay_q.push_back($urandom());
        load(8'h10, 1);
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({words_loaded, start, im_addr, err, busy} !== {5'd16, 1'b1, 4'd15, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL full_depth: got wl=%0d start=%b addr=%0d err=%b busy=%b, required 16 1 15 0 0",
                     words_loaded, start, im_addr, err, busy);
        end
        check_queue_empty("full_depth_writes");
    endtask

    task automatic test_hdr_err(input logic [7:0] n);
        do_reset(1);
        send_byte(n, 0);
        send_byte(8'h13, 0);
        for (int i = 0; i < 5; i++) send_byte(8'h00, 0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        tests++;
        if ({err, in_ready, start, busy, words_loaded} !== {1'b1, 1'b0, 1'b0, 1'b0, 5'd0}) begin
            fails++;
            $display("FAIL hdr_err_%h: got err=%b rdy=%b start=%b busy=%b wl=%0d, required 1 0 0 0 0",
                     n, err, in_ready, start, busy, words_loaded);
        end
    endtask

    task automatic test_mid_reset();
        do_reset(1);
        exp_q.push_back({4'd0, 32'h4433_2211});
        send_byte(8'h03, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        send_byte(8'h44, 0);
        send_byte(8'h55, 0);
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL mid_load_busy: got busy=%b, required 1", busy);
        end
        do_reset(1);
        check_idle("mid_reset_values");
        repeat (3) @(posedge clk);
        #1;
        check_queue_empty("mid_reset_writes");
        pay_q = '{32'hDDCC_BBAA};
        load(8'h01, 0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        tests++;
        if ({start, words_loaded} !== {1'b1, 5'd1}) begin
            fails++;
            $display("FAIL reload: got start=%b wl=%0d, required 1 1", start, words_loaded);
        end
        check_queue_empty("reload_writes");
    endtask

    task automatic test_post_done();
        in_valid = 1'b1;
        in_data  = 8'hFF;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            tests++;
            if ({start, in_ready, busy, words_loaded} !== {1'b1, 1'b0, 1'b0, 5'd1}) begin
                fails++;
                $display("FAIL post_done_%0d: got start=%b rdy=%b busy=%b wl=%0d, required 1 0 0 1",
                         i, start, in_ready, busy, words_loaded);
            end
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        tests++;
        if ({start, in_ready} !== 2'b01) begin
            fails++;
            $display("FAIL post_done_reset: got start=%b rdy=%b, required 0 1", start, in_ready);
        end
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        test_reset();
        test_two_word();
        test_full_gaps();
        test_hdr_err(8'h00);
        test_hdr_err(8'h11);
        test_mid_reset();
        test_post_done();
        repeat (2) @(posedge clk);
        #1;
        check_queue_empty("final_writes");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
